// File: rtl/edge_update_queue.sv
// rtl/edge_update_queue.sv - Avalon-fed FWFT queue of Bellman-Ford edge updates
// Entries are {src, dst, weight}; src/dst come from a staging register written separately.
module edge_update_queue #(
   parameter int PRED_W   = 4,
   parameter int WEIGHT_W = 32,
   parameter int DEPTH    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                chipselect,
   input  logic                write,
   input  logic                read,
   input  logic [2:0]          address,
   input  logic [WEIGHT_W-1:0] writedata,
   output logic [31:0]         readdata,
   output logic                upd_valid,
   input  logic                upd_ready,
   output logic [PRED_W-1:0]   upd_src,
   output logic [PRED_W-1:0]   upd_dst,
   output logic [WEIGHT_W-1:0] upd_w
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * PRED_W + WEIGHT_W;

   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [7:0]        drop_cnt;
   logic [PRED_W-1:0] stg_src;
   logic [PRED_W-1:0] stg_dst;

   logic       bus_wr;
   logic       bus_rd;
   logic       push_req;
   logic       flush;
   logic       pop;
   logic       full;
   logic       do_push;
   logic [7:0] cnt8;

   assign bus_wr   = chipselect && write;
   assign bus_rd   = chipselect && read;
   assign push_req = bus_wr && (address == 3'd1);
   assign flush    = bus_wr && (address == 3'd2);
   assign upd_valid = (count != '0);
   assign pop      = upd_valid && upd_ready && !flush;
   assign full     = (count == CW'(DEPTH));
   // A push into a full queue still lands when the head leaves in the same cycle.
   assign do_push  = push_req && (!full || pop);
   assign cnt8     = 8'(count);

   assign {upd_src, upd_dst, upd_w} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset && do_push)
         mem[wr_ptr] <= {stg_src, stg_dst, writedata};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
         stg_src  <= '0;
         stg_dst  <= '0;
      end else begin
         if (bus_wr && (address == 3'd0)) begin
            stg_src <= writedata[2*PRED_W-1:PRED_W];
            stg_dst <= writedata[PRED_W-1:0];
         end
         if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
         end else begin
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            if (do_push)
               wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            if (push_req && !do_push) begin
               overflow <= 1'b1;
               if (drop_cnt != 8'hFF)
                  drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= 32'd0;
      end else if (bus_rd) begin
         case (address)
            3'd3:    readdata <= {15'd0, overflow, drop_cnt, cnt8};
            3'd4:    readdata <= 32'({stg_src, stg_dst});
            default: readdata <= 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_update_queue.sv
// tb/tb_edge_update_queue.sv - self-checking bench for edge_update_queue
// Reference model is a queue of {src,dst,w} entries updated once per clock edge.
module tb_edge_update_queue;

   logic        clk;
   logic        reset;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        upd_valid;
   logic        upd_ready;
   logic [3:0]  upd_src;
   logic [3:0]  upd_dst;
   logic [31:0] upd_w;

   int total = 0;
   int bad   = 0;

   logic [39:0] mq[$];
   logic        m_ovf;
   int          m_drops;
   logic [3:0]  m_src;
   logic [3:0]  m_dst;
   logic [31:0] m_rd;

   edge_update_queue #(.PRED_W(4), .WEIGHT_W(32), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .read(read), .address(address), .writedata(writedata),
      .readdata(readdata), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_src(upd_src), .upd_dst(upd_dst), .upd_w(upd_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one cycle of inputs, advance the model, then sample #1 after the edge.
   task automatic cycle(input logic c, input logic w, input logic r,
                        input logic [2:0] a, input logic [31:0] d, input logic rdy);
      logic pop;
      logic [31:0] nrd;
      chipselect = c; write = w; read = r; address = a; writedata = d; upd_ready = rdy;
      nrd = m_rd;
      if (c && r)
         nrd = (a == 3'd3) ? {15'd0, m_ovf, 8'(m_drops), 8'(mq.size())} :
               (a == 3'd4) ? {24'd0, m_src, m_dst} : 32'd0;
      if (reset) begin
         mq.delete(); m_ovf = 0; m_drops = 0; m_src = 0; m_dst = 0; nrd = 0;
      end else if (c && w && a == 3'd2) begin
         mq.delete(); m_ovf = 0; m_drops = 0;
      end else begin
         pop = (mq.size() != 0) && rdy;
         if (pop) void'(mq.pop_front());
         if (c && w && a == 3'd1) begin
            if (mq.size() == 16) begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end else begin
               mq.push_back({m_src, m_dst, d});
            end
         end
         if (c && w && a == 3'd0) begin
            m_src = d[7:4]; m_dst = d[3:0];
         end
      end
      m_rd = nrd;
      @(posedge clk);
      #1;
      chipselect = 0; write = 0; read = 0; upd_ready = 0;
   endtask

   task automatic stage(input logic [7:0] sd); cycle(1, 1, 0, 3'd0, {24'd0, sd}, 0); endtask
   task automatic push(input logic [31:0] w);  cycle(1, 1, 0, 3'd1, w, 0); endtask
   task automatic flush();                     cycle(1, 1, 0, 3'd2, 32'd0, 0); endtask
   task automatic rdreg(input logic [2:0] a);  cycle(1, 0, 1, a, 32'd0, 0); endtask

   task automatic test_reset();
      reset = 1;
      cycle(1, 1, 0, 3'd1, 32'hDEAD, 1);
      cycle(1, 0, 1, 3'd4, 32'd0, 0);
      reset = 0;
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", upd_valid); end
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
      rdreg(3'd3);
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_status got=%h exp=0", readdata); end
      rdreg(3'd4);
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_staged got=%h exp=0", readdata); end
   endtask

   task automatic test_basic();
      stage(8'h23);
      push(32'h100);
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", upd_valid); end
      total++; if ({upd_src, upd_dst, upd_w} !== {4'd2, 4'd3, 32'h100})
         begin bad++; $display("FAIL basic_head got=%h/%h/%h exp=2/3/100", upd_src, upd_dst, upd_w); end
      rdreg(3'd3);
      total++; if (readdata !== 32'd1) begin bad++; $display("FAIL basic_count got=%h exp=1", readdata); end
   endtask

   task automatic test_fifo_order();
      flush();
      for (int i = 0; i < 16; i++) push(i);
      for (int i = 0; i < 16; i++) begin
         total++; if (upd_valid !== 1'b1 || upd_w !== 32'(i))
            begin bad++; $display("FAIL fifo_pop%0d got=%b/%0d exp=1/%0d", i, upd_valid, upd_w, i); end
         cycle(0, 0, 0, 3'd0, 32'd0, 1);
      end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty got=%b exp=0", upd_valid); end
      cycle(0, 0, 0, 3'd0, 32'd0, 1);
      rdreg(3'd3);
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL fifo_count got=%h exp=0", readdata); end
   endtask

   task automatic test_overflow();
      flush();
      for (int i = 0; i < 19; i++) push(i);
      rdreg(3'd3);
      total++; if (readdata !== {15'd0, 1'b1, 8'd3, 8'd16})
         begin bad++; $display("FAIL ovf_status got=%h exp=%h", readdata, {15'd0, 1'b1, 8'd3, 8'd16}); end
      total++; if (upd_w !== 32'd0) begin bad++; $display("FAIL ovf_head got=%0d exp=0", upd_w); end
   endtask

   task automatic test_full_push_pop();
      flush();
      for (int i = 0; i < 16; i++) push(i);
      cycle(1, 1, 0, 3'd1, 32'd99, 1);
      rdreg(3'd3);
      total++; if (readdata !== {15'd0, 1'b0, 8'd0, 8'd16})
         begin bad++; $display("FAIL fullpp_status got=%h exp=%h", readdata, {15'd0, 1'b0, 8'd0, 8'd16}); end
      for (int i = 1; i < 17; i++) begin
         total++; if (upd_valid !== 1'b1 || upd_w !== ((i == 16) ? 32'd99 : 32'(i)))
            begin bad++; $display("FAIL fullpp_pop%0d got=%b/%0d", i, upd_valid, upd_w); end
         cycle(0, 0, 0, 3'd0, 32'd0, 1);
      end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL fullpp_empty got=%b exp=0", upd_valid); end
   endtask

   task automatic test_flush();
      stage(8'h5A);
      for (int i = 0; i < 5; i++) push(32'h40 + i);
      cycle(1, 1, 0, 3'd2, 32'd0, 1);
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", upd_valid); end
      rdreg(3'd3);
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL flush_status got=%h exp=0", readdata); end
      rdreg(3'd4);
      total++; if (readdata !== 32'h5A) begin bad++; $display("FAIL flush_staged got=%h exp=5a", readdata); end
   endtask

   task automatic test_reset_mid();
      flush();
      for (int i = 0; i < 17; i++) push(i);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 3'd0, 32'd0, 1);
      rdreg(3'd3);
      total++; if (readdata !== {15'd0, 1'b1, 8'd1, 8'd7})
         begin bad++; $display("FAIL mid_pre got=%h exp=%h", readdata, {15'd0, 1'b1, 8'd1, 8'd7}); end
      reset = 1;
      cycle(1, 1, 0, 3'd1, 32'd7, 1);
      reset = 0;
      total++; if (upd_valid !== 1'b0 || readdata !== 32'd0)
         begin bad++; $display("FAIL mid_reset got=%b/%h exp=0/0", upd_valid, readdata); end
      rdreg(3'd3);
      total++; if (readdata !== 32'd0) begin bad++; $display("FAIL mid_status got=%h exp=0", readdata); end
      stage(8'h91);
      push(32'hCAFE);
      total++; if ({upd_valid, upd_src, upd_dst, upd_w} !== {1'b1, 4'd9, 4'd1, 32'hCAFE})
         begin bad++; $display("FAIL mid_push got=%b/%h/%h/%h exp=1/9/1/cafe", upd_valid, upd_src, upd_dst, upd_w); end
      cycle(0, 0, 0, 3'd0, 32'd0, 1);
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL mid_pop got=%b exp=0", upd_valid); end
   endtask

   task automatic test_random();
      logic [2:0] a;
      for (int n = 0; n < 600; n++) begin
         a = 3'($urandom_range(0, 7));
         if (a == 3'd2 && $urandom_range(0, 15) != 0) a = 3'd1;
         if (a >= 3'd5 && $urandom_range(0, 1) != 0) a = 3'd1;
         cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               a, $urandom, 1'($urandom_range(0, 2) == 0));
         total++; if (upd_valid !== (mq.size() != 0))
            begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, upd_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            total++; if ({upd_src, upd_dst, upd_w} !== mq[0])
               begin bad++; $display("FAIL rnd_head n=%0d got=%h exp=%h", n, {upd_src, upd_dst, upd_w}, mq[0]); end
         end
         total++; if (readdata !== m_rd)
            begin bad++; $display("FAIL rnd_readdata n=%0d got=%h exp=%h", n, readdata, m_rd); end
      end
   endtask

   initial begin
      reset = 0; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0; upd_ready = 0;
      mq.delete(); m_ovf = 0; m_drops = 0; m_src = 0; m_dst = 0; m_rd = 0;
      test_reset();
      test_basic();
      test_fifo_order();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/edge_update_queue.md
EDGE_UPDATE_QUEUE -- requirements
Module: edge_update_queue

Interface
REQ-001 Parameter: PRED_W, default 4, bit width of a vertex (currency) index.
REQ-002 Parameter: WEIGHT_W, default 32, bit width of an edge weight (two's complement).
REQ-003 Parameter: DEPTH, default 16, queue entries; SHALL be a power of two, at least 2.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: chipselect  in  1  Avalon slave select.
REQ-007 Port: write  in  1  Avalon write strobe; acts only when chipselect=1.
REQ-008 Port: read  in  1  Avalon read strobe; acts only when chipselect=1.
REQ-009 Port: address  in  3  Avalon word address.
REQ-010 Port: writedata  in  WEIGHT_W  Avalon write data.
REQ-011 Port: readdata  out  32  Avalon read data, registered.
REQ-012 Port: upd_valid  out  1  head entry available to the Bellman-Ford container.
REQ-013 Port: upd_ready  in  1  container accepts head entry this cycle.
REQ-014 Port: upd_src, upd_dst  out  PRED_W each  head entry vertex indices.
REQ-015 Port: upd_w  out  WEIGHT_W  head entry weight.

Function
REQ-016 Bus write (chipselect&write) decoding: addr 0 stages src=writedata[2*PRED_W-1:PRED_W] and dst=writedata[PRED_W-1:0]; addr 1 pushes {staged src, staged dst, writedata} as one entry; addr 2 flushes; other addresses ignored.
REQ-017 Staged src/dst persist across pushes; repeated addr-1 writes reuse the last staged pair.
REQ-018 Queue SHALL be FIFO ordered, first-word-fall-through: upd_valid = (count != 0); upd_src/dst/w show head entry combinationally from storage.
REQ-019 Pop occurs when upd_valid & upd_ready; read pointer advances, wrapping modulo DEPTH.
REQ-020 Push-to-visible latency: entry pushed at edge N SHALL drive upd_valid=1 after edge N (usable cycle N+1) when queue was empty.
REQ-021 count range 0..DEPTH; push only: +1; pop only: -1; push and pop same cycle: unchanged, both performed, including when count=DEPTH.
REQ-022 Push when count=DEPTH with no simultaneous pop: entry discarded, sticky overflow flag set, drop_cnt (8 bit) increments, saturating at 255.
REQ-023 Flush: pointers and count to 0, overflow and drop_cnt cleared; staged src/dst retained; flush takes priority over any same-cycle pop (no pop occurs).
REQ-024 upd_ready while upd_valid=0 SHALL have no effect.
REQ-025 Bus read (chipselect&read), readdata loaded next edge: addr 3 = {15'b0, overflow, drop_cnt[7:0], count zero-extended to 8 bits}; addr 4 = staged {src,dst} zero-extended; other addresses return 0.
REQ-026 readdata SHALL hold its value when no bus read occurs.
REQ-027 Queue state SHALL only change via push, pop, flush, or reset.

Reset
REQ-028 reset=1 at an edge: count, read/write pointers, overflow, drop_cnt, staged src/dst, readdata all 0; upd_valid=0 the following cycle.
REQ-029 reset SHALL override any same-cycle write, read, push, pop, or flush.
REQ-030 Storage array contents need not be cleared; upd_src/dst/w are don't-care while upd_valid=0.

Verification
REQ-031 Reset, write addr0=0x0023, addr1=0x00000100, upd_ready=0 -> next cycle upd_valid=1, upd_src=2, upd_dst=3, upd_w=0x100, addr3 read count=1.
REQ-032 Push 16 entries w=0..15 with upd_ready=0, then upd_ready=1 -> 16 pops in order 0..15, then upd_valid=0, count=0.
REQ-033 Fill to 16, push 3 more with no pop -> overflow=1, drop_cnt=3, count=16, head still w=0.
REQ-034 count=16, push w=99 and upd_ready=1 same cycle -> count stays 16, overflow stays 0, w=99 emerges as the 16th pop.
REQ-035 count=5, flush write with upd_ready=1 same cycle -> count=0, upd_valid=0, overflow=0, drop_cnt=0; next addr4 read returns last staged pair.
REQ-036 count=7 with overflow=1, assert reset mid-stream -> all status 0, upd_valid=0; new push afterward dequeues normally.
